// File: rtl/srl32_fifo.sv
// First-word-fall-through FIFO controller built on WIDTH parallel SRLC32E-style
// shift-register lanes: shift-in at bit 0 on push, read tap at LEVEL-1.
module srl32_fifo #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DEPTH       = 32,
  parameter int unsigned AFULL_LEVEL = 28,
  parameter logic        INIT_VAL    = 1'b0
) (
  input  logic             CLK,
  input  logic             ARESETN,
  input  logic [WIDTH-1:0] S_DATA,
  input  logic             S_VALID,
  output logic             S_READY,
  output logic [WIDTH-1:0] M_DATA,
  output logic             M_VALID,
  input  logic             M_READY,
  output logic [5:0]       LEVEL,
  output logic             ALMOST_FULL,
  output logic             OVERFLOW
);

  localparam logic [5:0] DEPTH_L = 6'(DEPTH);
  localparam logic [5:0] AFULL_L = 6'(AFULL_LEVEL);

  logic [5:0]       level_q;
  logic [5:0]       level_d;
  logic             overflow_q;
  logic             overflow_d;
  logic             push_s;
  logic             pop_s;
  logic [4:0]       tap_s;
  logic [WIDTH-1:0] tap_data_s;
  logic [31:0]      srl_q [WIDTH];

  // Flags decode from the level register alone, so no ready/valid loops form.
  always_comb begin
    S_READY     = (level_q < DEPTH_L);
    M_VALID     = (level_q != 6'd0);
    ALMOST_FULL = (level_q >= AFULL_L);
    push_s      = S_VALID & S_READY;
    pop_s       = M_VALID & M_READY;
    tap_s       = level_q[4:0] - 5'd1;
    level_d     = level_q;
    case ({push_s, pop_s})
      2'b10:   level_d = level_q + 6'd1;
      2'b01:   level_d = level_q - 6'd1;
      default: level_d = level_q;
    endcase
    overflow_d  = overflow_q | (S_VALID & ~S_READY);
  end

  always_ff @(posedge CLK or negedge ARESETN) begin
    if (!ARESETN) begin
      level_q    <= 6'd0;
      overflow_q <= 1'b0;
    end else begin
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is deliberately unreset; stale words are unreachable once LEVEL is 0.
  always_ff @(posedge CLK) begin
    if (push_s) begin
      for (int b = 0; b < WIDTH; b++) begin
        srl_q[b] <= {srl_q[b][30:0], S_DATA[b]};
      end
    end
  end

  // Empty FIFO presents a fixed pattern so M_DATA never carries unknowns.
  always_comb begin
    tap_data_s = '0;
    for (int b = 0; b < WIDTH; b++) begin
      tap_data_s[b] = srl_q[b][tap_s];
    end
    if (M_VALID) begin
      M_DATA = tap_data_s;
    end else begin
      M_DATA = {WIDTH{INIT_VAL}};
    end
  end

  assign LEVEL    = level_q;
  assign OVERFLOW = overflow_q;

endmodule

// File: tb/tb_srl32_fifo.sv
// Directed + randomized bench for srl32_fifo checked against a queue-based model.
module tb_srl32_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 32;
  localparam int AFULL = 28;

  logic             CLK = 1'b0;
  logic             ARESETN;
  logic [WIDTH-1:0] S_DATA;
  logic             S_VALID;
  logic             S_READY;
  logic [WIDTH-1:0] M_DATA;
  logic             M_VALID;
  logic             M_READY;
  logic [5:0]       LEVEL;
  logic             ALMOST_FULL;
  logic             OVERFLOW;

  int n_checks = 0;
  int n_fail   = 0;
  logic [WIDTH-1:0] model_q[$];
  logic model_ovf = 1'b0;

  srl32_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_LEVEL(AFULL), .INIT_VAL(1'b0)) dut (
    .CLK(CLK), .ARESETN(ARESETN), .S_DATA(S_DATA), .S_VALID(S_VALID), .S_READY(S_READY),
    .M_DATA(M_DATA), .M_VALID(M_VALID), .M_READY(M_READY), .LEVEL(LEVEL),
    .ALMOST_FULL(ALMOST_FULL), .OVERFLOW(OVERFLOW)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int lvl;
    lvl = model_q.size();
    chk({tag, ".level"}, 64'(LEVEL), 64'(lvl));
    chk({tag, ".m_valid"}, 64'(M_VALID), 64'(lvl != 0));
    chk({tag, ".s_ready"}, 64'(S_READY), 64'(lvl < DEPTH));
    chk({tag, ".afull"}, 64'(ALMOST_FULL), 64'(lvl >= AFULL));
    chk({tag, ".overflow"}, 64'(OVERFLOW), 64'(model_ovf));
    if (lvl != 0) chk({tag, ".m_data"}, 64'(M_DATA), 64'(model_q[0]));
  endtask

  // One clock: drive inputs, predict from pre-edge model state, check #1 after edge.
  task automatic step(input string tag, input logic sv, input logic [WIDTH-1:0] d, input logic mr);
    logic do_push, do_pop;
    S_VALID = sv;
    S_DATA  = d;
    M_READY = mr;
    do_push = sv && (model_q.size() < DEPTH);
    do_pop  = mr && (model_q.size() > 0);
    if (sv && model_q.size() >= DEPTH) model_ovf = 1'b1;
    @(posedge CLK);
    if (do_pop) void'(model_q.pop_front());
    if (do_push) model_q.push_back(d);
    #1;
    check_all(tag);
  endtask

  task automatic drain();
    int n;
    n = model_q.size();
    for (int i = 0; i < n; i++) step("drain", 1'b0, 8'h00, 1'b1);
  endtask

  initial begin
    logic [WIDTH-1:0] held;
    ARESETN = 1'b0;
    S_VALID = 1'b0;
    S_DATA  = 8'h00;
    M_READY = 1'b0;
    #2;
    check_all("por");
    repeat (2) @(posedge CLK);
    #1;
    ARESETN = 1'b1;
    check_all("reset");

    // Single push, then hold stable while idle
    step("push_a5", 1'b1, 8'hA5, 1'b0);
    chk("a5.data", 64'(M_DATA), 64'hA5);
    held = M_DATA;
    for (int i = 0; i < 5; i++) begin
      step("idle", 1'b0, 8'h00, 1'b0);
      chk("a5.stable", 64'(M_DATA), 64'(held));
    end
    // Head stays stable while pushes arrive behind it
    for (int i = 0; i < 3; i++) begin
      step("push_behind", 1'b1, 8'(8'h50 + i), 1'b0);
      chk("head.stable", 64'(M_DATA), 64'hA5);
    end
    drain();

    // Empty: M_READY ignored; push with M_READY same cycle not popped
    step("empty_rdy", 1'b0, 8'h00, 1'b1);
    chk("empty.level", 64'(LEVEL), 64'd0);
    step("empty_push_rdy", 1'b1, 8'h77, 1'b1);
    chk("empty_push.level", 64'(LEVEL), 64'd1);
    drain();

    // Fill to DEPTH, overflow attempt, drain in order
    for (int i = 0; i < DEPTH; i++) step("fill", 1'b1, 8'(i), 1'b0);
    chk("full.level", 64'(LEVEL), 64'd32);
    chk("full.s_ready", 64'(S_READY), 64'd0);
    step("ovf_push", 1'b1, 8'hFF, 1'b0);
    chk("ovf.flag", 64'(OVERFLOW), 64'd1);
    chk("ovf.level", 64'(LEVEL), 64'd32);
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain.order", 64'(M_DATA), 64'(i));
      step("drain_full", 1'b0, 8'h00, 1'b1);
    end
    chk("drained.level", 64'(LEVEL), 64'd0);

    // Full with simultaneous push and pop: only the pop completes
    for (int i = 0; i < DEPTH; i++) step("refill", 1'b1, 8'(8'h80 + i), 1'b0);
    step("full_pushpop", 1'b1, 8'hEE, 1'b1);
    chk("fpp.level", 64'(LEVEL), 64'd31);
    chk("fpp.s_ready", 64'(S_READY), 64'd1);
    drain();

    // Sustained throughput at LEVEL=5
    for (int i = 0; i < 5; i++) step("pre5", 1'b1, 8'(i), 1'b0);
    for (int i = 5; i < 105; i++) begin
      chk("thru.out", 64'(M_DATA), 64'((i - 5) & 8'hFF));
      step("thru", 1'b1, 8'(i), 1'b1);
      chk("thru.level", 64'(LEVEL), 64'd5);
    end
    drain();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step("rand", 1'($urandom_range(0, 99) < 55), 8'($urandom), 1'($urandom_range(0, 99) < 45));
    end
    drain();

    // Asynchronous reset mid-stream at LEVEL=17
    for (int i = 0; i < 17; i++) step("pre17", 1'b1, 8'(8'hC0 + i), 1'b0);
    chk("pre17.level", 64'(LEVEL), 64'd17);
    #2;
    ARESETN = 1'b0;
    #1;
    model_q.delete();
    model_ovf = 1'b0;
    check_all("async_rst");
    @(posedge CLK);
    #1;
    ARESETN = 1'b1;
    check_all("rst_release");
    step("post_rst_push", 1'b1, 8'h3C, 1'b0);
    chk("post_rst.data", 64'(M_DATA), 64'h3C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
